// File: rtl/torradeira_ctrl.sv
// Toaster controller: debounced-free pushbutton handling (two-flop sync plus
// falling-edge detect), one-second prescaler, and a three-state FSM that
// counts the toasting time down and then counts elapsed seconds since done.
`timescale 1ns/1ps

module torradeira_ctrl #(
    parameter int TICK_MAX  = 49_999_999,
    parameter int MAX_LEVEL = 9
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start_n,
    input  logic       cancel_n,
    input  logic [3:0] level,
    output logic       heater,
    output logic       done,
    output logic [3:0] tempo,
    output logic [3:0] tempoCres,
    output logic [1:0] state
);

    localparam int PW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_TOAST = 2'b01,
        S_DONE  = 2'b10,
        S_BAD   = 2'b11
    } state_t;

    // Button synchronizers and previous-cycle samples for edge detection.
    logic start_s1_q,  start_s1_d,  start_s2_q,  start_s2_d,  start_prev_q,  start_prev_d;
    logic cancel_s1_q, cancel_s1_d, cancel_s2_q, cancel_s2_d, cancel_prev_q, cancel_prev_d;

    // Counts the first edges after reset release; until the synchronizer has
    // been refilled with real samples, a low button must not look like a press.
    logic [1:0]    settle_q, settle_d;
    logic [PW-1:0] presc_q,  presc_d;
    state_t        state_q,  state_d;
    logic [3:0]    tempo_q,  tempo_d;
    logic [3:0]    tempo_cres_q, tempo_cres_d;

    logic       armed;
    logic       start_press;
    logic       cancel_press;
    logic       start_ev;
    logic       tick;
    logic [3:0] eff_level;

    assign armed        = (settle_q == 2'd3);
    assign start_press  = armed && !start_s2_q && start_prev_q;
    assign cancel_press = armed && !cancel_s2_q && cancel_prev_q;
    // Cancel always wins over a simultaneous start.
    assign start_ev     = start_press && !cancel_press;
    assign tick         = (presc_q == PW'(TICK_MAX));
    assign eff_level    = (level > 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level;

    // Synchronizer, edge-detect and settle-counter next values.
    always_comb begin
        start_s1_d    = start_n;
        start_s2_d    = start_s1_q;
        start_prev_d  = start_s2_q;
        cancel_s1_d   = cancel_n;
        cancel_s2_d   = cancel_s1_q;
        cancel_prev_d = cancel_s2_q;
        settle_d      = armed ? settle_q : settle_q + 2'd1;
    end

    // FSM next state, countdown/count-up values and prescaler.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d      = state_q;
        tempo_d      = tempo_q;
        tempo_cres_d = tempo_cres_q;
        case (state_q)
            S_IDLE: begin
                tempo_d      = eff_level;
                tempo_cres_d = 4'd0;
                if (start_ev && eff_level != 4'd0) begin
                    state_d = S_TOAST;
                end
            end
            S_TOAST: begin
                if (cancel_press) begin
                    state_d = S_IDLE;
                    tempo_d = eff_level;
                end else if (tick) begin
                    if (tempo_q > 4'd1) begin
                        tempo_d = tempo_q - 4'd1;
                    end else begin
                        tempo_d = 4'd0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                tempo_d = 4'd0;
                if (cancel_press || start_press) begin
                    state_d      = S_IDLE;
                    tempo_d      = eff_level;
                    tempo_cres_d = 4'd0;
                end else if (tick && tempo_cres_q < 4'd9) begin
                    tempo_cres_d = tempo_cres_q + 4'd1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                tempo_d      = eff_level;
                tempo_cres_d = 4'd0;
            end
        endcase
        // Every transition restarts the second so it lasts a full period.
        if (state_d != state_q || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            start_s1_q    <= 1'b1;
            start_s2_q    <= 1'b1;
            start_prev_q  <= 1'b1;
            cancel_s1_q   <= 1'b1;
            cancel_s2_q   <= 1'b1;
            cancel_prev_q <= 1'b1;
            settle_q      <= 2'd0;
            presc_q       <= '0;
            state_q       <= S_IDLE;
            tempo_q       <= 4'd0;
            tempo_cres_q  <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            start_s1_q    <= start_s1_d;
            start_s2_q    <= start_s2_d;
            start_prev_q  <= start_prev_d;
            cancel_s1_q   <= cancel_s1_d;
            cancel_s2_q   <= cancel_s2_d;
            cancel_prev_q <= cancel_prev_d;
            settle_q      <= settle_d;
            presc_q       <= presc_d;
            state_q       <= state_d;
            tempo_q       <= tempo_d;
            tempo_cres_q  <= tempo_cres_d;
        end
    end

    assign heater    = (state_q == S_TOAST);
    assign done      = (state_q == S_DONE);
    assign tempo     = tempo_q;
    assign tempoCres = tempo_cres_q;
    assign state     = state_q;

endmodule

// File: tb/tb_torradeira_ctrl.sv
// Scoreboard bench for torradeira_ctrl (TICK_MAX=9). Stimulus tasks derive the
// expected timeline of output changes from the toaster rules (3-edge button
// latency, 10-cycle seconds, clamp at 9) and queue them; a monitor pops one
// entry for every change it sees on the outputs and checks value and cycle.
`timescale 1ns/1ps

module tb_torradeira_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       start_n  = 1'b1;
    logic       cancel_n = 1'b1;
    logic [3:0] level    = 4'd0;
    logic       heater, done;
    logic [3:0] tempo, tempoCres;
    logic [1:0] state;

    torradeira_ctrl #(.TICK_MAX(9), .MAX_LEVEL(9)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start_n   (start_n),
        .cancel_n  (cancel_n),
        .level     (level),
        .heater    (heater),
        .done      (done),
        .tempo     (tempo),
        .tempoCres (tempoCres),
        .state     (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0] st;
        logic       h;
        logic       d;
        logic [3:0] t;
        logic [3:0] tc;
    } out_t;

    typedef struct {
        out_t v;
        int   at;
    } exp_t;

    exp_t sb_q[$];
    out_t model_v = '0;
    out_t prev_v  = '0;
    out_t dut_v;
    int   tests_run    = 0;
    int   tests_failed = 0;

    assign dut_v = {state, heater, done, tempo, tempoCres};

    function automatic out_t mk(input int st, input int h, input int d, input int t, input int tc);
        out_t r;
        r.st = 2'(st);
        r.h  = 1'(h);
        r.d  = 1'(d);
        r.t  = 4'(t);
        r.tc = 4'(tc);
        return r;
    endfunction

    function automatic int eff(input int l);
        return (l > 9) ? 9 : l;
    endfunction

    function automatic out_t idle_v(input int l);
        return mk(0, 0, 0, eff(l), 0);
    endfunction

    function automatic string fmt(input out_t v);
        return $sformatf("st=%0d h=%0d d=%0d t=%0d tc=%0d", v.st, v.h, v.d, v.t, v.tc);
    endfunction

    task automatic check(input bit ok, input string name, input string detail);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Queue an expected output vector for a given cycle, only if it differs
    // from what the outputs are already expected to show.
    task automatic expect_at(input out_t v, input int at);
        if (v != model_v) begin
            sb_q.push_back('{v: v, at: at});
            model_v = v;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge CLOCK_50);
            #1;
        end
    endtask

    task automatic wait_n(input int n);
        goto(cyc + n);
    endtask

    // Monitor: every change of the output vector consumes one expectation.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (dut_v !== prev_v) begin
                if (sb_q.size() == 0) begin
                    check(1'b0 == 1'b1 && sb_q.size() != 0, "unexpected_change",
                          $sformatf("got %s @%0d, want no change", fmt(dut_v), cyc));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check(dut_v === e.v && cyc == e.at, "output_change",
                          $sformatf("got %s @%0d, want %s @%0d", fmt(dut_v), cyc, fmt(e.v), e.at));
                end
                prev_v = dut_v;
            end
        end
    end

    task automatic set_level(input int l);
        level = 4'(l);
        expect_at(idle_v(l), cyc + 1);
        wait_n(2);
    endtask

    // One toasting session from IDLE. cancel_at > 0: cancel takes effect that
    // many cycles after TOAST entry; otherwise run to DONE, wait done_wait
    // cycles, then leave with start (exit_start) or cancel. lchg >= 0 changes
    // the level switches during TOAST.
    task automatic toast(input int lreq, input int lchg, input int cancel_at,
                         input int done_wait, input bit exit_start);
        int e, c, t0, td, x, ce, lfin;
        e    = eff(lreq);
        lfin = (lchg >= 0) ? lchg : lreq;
        c    = cyc;
        if (e == 0) begin
            start_n = 1'b0;
            wait_n(3);
            start_n = 1'b1;
            wait_n(20);
            return;
        end
        t0 = c + 3;
        td = t0 + 10 * e;
        ce = 0;
        expect_at(mk(1, 1, 0, e, 0), t0);
        x = (cancel_at > 0) ? t0 + cancel_at : td;
        for (int k = 1; k < e; k++)
            if (t0 + 10 * k < x) expect_at(mk(1, 1, 0, e - k, 0), t0 + 10 * k);
        if (cancel_at > 0) begin
            expect_at(idle_v(lfin), x);
        end else begin
            expect_at(mk(2, 0, 1, 0, 0), td);
            ce = td + done_wait;
            x  = ce + 3;
            for (int n = 1; n <= 9; n++)
                if (td + 10 * n < x) expect_at(mk(2, 0, 1, 0, n), td + 10 * n);
            expect_at(idle_v(lfin), x);
        end
        start_n = 1'b0;
        wait_n($urandom_range(1, 3));
        start_n = 1'b1;
        if (lchg >= 0) begin
            goto(t0 + 2);
            level = 4'(lchg);
        end
        if (cancel_at > 0) begin
            goto(x - 3);
            cancel_n = 1'b0;
            wait_n($urandom_range(1, 4));
            cancel_n = 1'b1;
        end else begin
            goto(ce);
            if (exit_start) start_n = 1'b0;
            else            cancel_n = 1'b0;
            wait_n($urandom_range(1, 20));
            start_n  = 1'b1;
            cancel_n = 1'b1;
        end
        goto(x + 2);
        wait_n(4);
    endtask

    task automatic press_both();
        start_n  = 1'b0;
        cancel_n = 1'b0;
        wait_n(3);
        start_n  = 1'b1;
        cancel_n = 1'b1;
        wait_n(30);
    endtask

    // Reset while TOAST shows tempo=4, then release with start still held.
    task automatic reset_mid(input int l);
        int e, t0, r;
        e  = eff(l);
        t0 = cyc + 3;
        expect_at(mk(1, 1, 0, e, 0), t0);
        for (int k = 1; k <= e - 4; k++) expect_at(mk(1, 1, 0, e - k, 0), t0 + 10 * k);
        r = t0 + 10 * (e - 4) + 3;
        expect_at(mk(0, 0, 0, 0, 0), r + 1);
        expect_at(idle_v(l), r + 6);
        start_n = 1'b0;
        wait_n(2);
        start_n = 1'b1;
        goto(r);
        start_n = 1'b0;
        reset   = 1'b0;
        #1;
        check(heater === 1'b0 && state === 2'b00, "reset_immediate",
              $sformatf("got heater=%0b state=%0d, want heater=0 state=0", heater, state));
        goto(r + 5);
        reset = 1'b1;
        wait_n(40);
        start_n = 1'b1;
        wait_n(6);
    endtask

    initial begin
        #1 reset = 1'b0;
        level = 4'd3;
        @(negedge CLOCK_50);
        #1;
        wait_n(3);
        reset = 1'b1;
        expect_at(idle_v(3), cyc + 1);
        wait_n(6);

        toast(3, -1, 0, 15, 1'b1);           // basic countdown 3,2,1 -> DONE
        set_level(12);                       // clamp to 9
        toast(12, -1, 0, 20, 1'b0);
        set_level(0);
        toast(0, -1, 0, 0, 1'b0);            // ignored start
        set_level(6);
        toast(6, -1, 45, 0, 1'b0);           // cancel while tempo=2
        press_both();                        // cancel wins, stay IDLE
        set_level(4);
        toast(4, -1, 20, 0, 1'b0);           // cancel coincides with tick
        set_level(2);
        toast(2, -1, 0, 150, 1'b1);          // tempoCres saturates at 9
        set_level(5);
        toast(5, 2, 0, 30, 1'b0);            // level change ignored in TOAST
        set_level(7);
        reset_mid(7);

        for (int i = 0; i < 14; i++) begin
            int l, e, mode, lchg;
            l    = $urandom_range(0, 15);
            set_level(l);
            e    = eff(l);
            mode = $urandom_range(0, 2);
            lchg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
            if (mode == 2) press_both();
            else if (mode == 1 && e > 0) toast(l, lchg, $urandom_range(5, 10 * e - 1), 0, 1'b0);
            else toast(l, lchg, 0, $urandom_range(1, 110), 1'($urandom_range(0, 1)));
        end

        wait_n(20);
        check(sb_q.size() == 0, "scoreboard_drain",
              $sformatf("got %0d pending (first %s @%0d), want 0", sb_q.size(),
                        (sb_q.size() != 0) ? fmt(sb_q[0].v) : "none",
                        (sb_q.size() != 0) ? sb_q[0].at : 0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
